reg_file_dumper: RTL and testbench
==================================

# reg_file_dumper

Sequential reader for the 32 x 32-bit register file: on command, walks a contiguous, wrapping address range through one register-file read port and streams each `{address, data}` pair out over a valid/ready handshake. It also keeps a running XOR checksum of the streamed words. It sits beside the datapath as a debug and test-bench observation port. It drives only a read-address port and never writes the register file.

## Interface
Parameters:
- `AW`, 5, register address width (32 registers)
- `DW`, 32, register data width

Ports:
- `clk`  input  1  system clock; all state changes on rising edge
- `rst`  input  1  reset, synchronous, active-low
- `start`  input  1  begin a dump; sampled only in IDLE
- `first_addr`  input  AW  first register to dump; latched with `start`
- `last_addr`  input  AW  last register to dump; latched with `start`
- `rf_addr`  output  AW  register-file read address; connect to A1 or A2
- `rf_data`  input  DW  combinational read data returned for `rf_addr`
- `out_valid`  output  1  `out_addr`/`out_data` hold a valid word
- `out_ready`  input  1  consumer accepts the word
- `out_addr`  output  AW  address of the streamed word
- `out_data`  output  DW  streamed register value
- `busy`  output  1  high in every state except IDLE
- `done`  output  1  one-cycle pulse after the last word is accepted
- `checksum`  output  DW  XOR of all words accepted in the current or last dump

## Operation
- States: IDLE, READ, HOLD, DONE.
- **IDLE**
  - `rf_addr` = 0, `out_valid` = 0, `busy` = 0.
  - When `start`=1: latch `first_addr` into the address counter and `last_addr` into the end register, clear `checksum`, go to READ.
- **READ** (one cycle)
  - `rf_addr` = counter.
  - At the clock edge: capture `rf_data` into `out_data` and the counter into `out_addr`, set `out_valid`, go to HOLD.
- **HOLD**
  - `out_valid` = 1; `out_addr` and `out_data` stay stable until accepted.
  - When `out_ready`=1:
    - `checksum` <= `checksum` ^ `out_data`.
    - `out_valid` drops.
    - If counter == end register: go to DONE.
    - Otherwise: counter <= counter + 1 (modulo 2^AW, so 31 wraps to 0), go to READ.
- **DONE** (one cycle)
  - `done` = 1, then go to IDLE.
  - `checksum` holds its value until the next `start`.
- Range and word count:
  - Words dumped = ((`last_addr` - `first_addr`) mod 32) + 1.
  - `first_addr` == `last_addr` dumps exactly one word.
  - `last_addr` < `first_addr` wraps through 31 → 0.
- Each word is a snapshot taken in its READ cycle. Register-file writes landing during HOLD do not alter the word being offered, but later words do see them.
- `start` is ignored in READ, HOLD and DONE. `first_addr` and `last_addr` are don't-care outside the `start` cycle.
- No arithmetic beyond the AW-bit wrapping increment and the DW-bit XOR.

## Timing
- Reset (`rst`=0 at an edge) forces:
  - state IDLE;
  - `rf_addr`, `out_addr`, `out_data`, `checksum` = 0;
  - `out_valid`, `busy`, `done` = 0.
- Reset mid-dump aborts immediately: no `done` pulse, and the partial checksum is cleared.
- Latency:
  - `start` sampled at edge k → READ in cycle k+1 → `out_valid` high from cycle k+2.
  - The first word is therefore visible 2 cycles after `start`.
- Throughput: 2 cycles per word with `out_ready` held high. N words with ready always high occupy 2N cycles of `busy`, plus 1 cycle of DONE.
- Handshake:
  - A transfer occurs on an edge where `out_valid` && `out_ready`.
  - `out_valid` never drops without a transfer, except on reset.
  - `out_ready` is allowed to be high before `out_valid`; it has no effect outside HOLD.
- Last-word acceptance at edge m → `done` = 1 in cycle m+1, `busy` = 0 and state IDLE in cycle m+2.
- A `start` asserted in the cycle after DONE (first IDLE cycle) is accepted.

## Test plan
- Registers preloaded with x_i = 0x1000_0000 + i; dump `first`=0, `last`=31, `out_ready` held 1 → 32 words, addresses 0..31 in order, data 0x1000_0000..0x1000_001F; `done` 64 cycles after the first READ cycle; final `checksum` = XOR of all 32 values = 0x0000_0000.
- `first`=30, `last`=1 → exactly 4 words at addresses 30, 31, 0, 1; `checksum` = x30^x31^x0^x1.
- `first`=`last`=5, `out_ready` low for 7 cycles → `out_valid` high with `out_addr`=5 and `out_data`=x5 stable all 7 cycles; one transfer when `out_ready` rises; then `done` pulse.
- Write x7 = 0xDEAD_BEEF during HOLD of word 6, in a dump of 6..8 → word 6 unchanged, word 7 = 0xDEAD_BEEF.
- Assert `start` with `first`=2 while busy mid-dump of 10..12 → ignored; stream stays 10, 11, 12.
- `rst`=0 during HOLD of word 3 of a 0..31 dump → next cycle all outputs 0, state IDLE, no `done`; a fresh `start` then dumps correctly from its own `first_addr`.

Source files
------------

// File: rtl/reg_file_dumper.sv
// Debug observation port: walks a wrapping register-file address range through one
// read port and streams {address, data} pairs over valid/ready with a running XOR checksum.
module reg_file_dumper #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] end_addr;
    logic          accept;

    assign accept = (state == HOLD) && out_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        rf_addr   = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = READ;
            end
            READ: begin
                rf_addr   = cnt;
                state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = (cnt == end_addr) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word is snapshotted in READ, so register-file writes during HOLD do not disturb it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            end_addr <= '0;
            out_addr <= '0;
            out_data <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= first_addr;
                        end_addr <= last_addr;
                        checksum <= '0;
                    end
                end
                READ: begin
                    out_addr <= cnt;
                    out_data <= rf_data;
                end
                HOLD: begin
                    if (accept) begin
                        checksum <= checksum ^ out_data;
                        if (cnt != end_addr) cnt <= cnt + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: the bench models the register file and checks
// stream order, wrap, stall stability, snapshot semantics, start-while-busy and reset abort.
module tb_reg_file_dumper;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic [31:0] regs [32];
    logic [4:0]  got_addr [$];
    logic [31:0] got_data [$];

    int checks   = 0;
    int failures = 0;

    assign rf_data = regs[rf_addr];

    reg_file_dumper #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] xval(input logic [4:0] a);
        return 32'h1000_0000 + {27'd0, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_regs();
        for (int i = 0; i < 32; i++) regs[i] = xval(5'(i));
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        start = 1'b1; first_addr = f; last_addr = l;
        step();
        start = 1'b0; first_addr = 5'($urandom); last_addr = 5'($urandom);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || rf_addr !== f) begin
            $display("FAIL read_cycle busy=%b valid=%b rf_addr=%0d exp busy=1 valid=0 rf_addr=%0d",
                     busy, out_valid, rf_addr, f);
            failures++;
        end
    endtask

    task automatic collect(input int max_t, output int done_t);
        got_addr.delete();
        got_data.delete();
        done_t = -1;
        for (int t = 0; t < max_t; t++) begin
            if (out_valid && out_ready) begin
                got_addr.push_back(out_addr);
                got_data.push_back(out_data);
            end
            if (done) begin
                done_t = t;
                break;
            end
            step();
        end
        checks++;
        if (done_t < 0) begin
            $display("FAIL done_timeout got=none exp=done within %0d cycles", max_t);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; first_addr = 5'd9; last_addr = 5'd9; out_ready = 1'b1;
        repeat (3) step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rf_addr !== 5'd0 ||
            out_addr !== 5'd0 || out_data !== 32'd0 || checksum !== 32'd0) begin
            $display("FAIL reset_state busy=%b done=%b valid=%b rf_addr=%0d out_addr=%0d data=%h sum=%h exp all zero",
                     busy, done, out_valid, rf_addr, out_addr, out_data, checksum);
            failures++;
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_full_dump();
        int done_t;
        init_regs();
        out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        collect(200, done_t);
        checks++;
        if (done_t !== 64) begin
            $display("FAIL full_done_latency got=%0d exp=64", done_t);
            failures++;
        end
        checks++;
        if (got_addr.size() != 32) begin
            $display("FAIL full_count got=%0d exp=32", got_addr.size());
            failures++;
        end
        for (int i = 0; i < got_addr.size() && i < 32; i++) begin
            logic [4:0] ea;
            ea = 5'(i);
            checks++;
            if (got_addr[i] !== ea || got_data[i] !== xval(ea)) begin
                $display("FAIL full_word%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_data[i], ea, xval(ea));
                failures++;
            end
        end
        checks++;
        if (checksum !== 32'h0000_0000) begin
            $display("FAIL full_checksum got=%h exp=00000000", checksum);
            failures++;
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL full_idle busy=%b done=%b exp busy=0 done=0", busy, done);
            failures++;
        end
    endtask

    task automatic test_wrap();
        int done_t;
        init_regs();
        out_ready = 1'b1;
        start_dump(5'd30, 5'd1);
        collect(50, done_t);
        checks++;
        if (got_addr.size() != 4) begin
            $display("FAIL wrap_count got=%0d exp=4", got_addr.size());
            failures++;
        end
        for (int i = 0; i < got_addr.size() && i < 4; i++) begin
            logic [4:0] ea;
            ea = 5'd30 + 5'(i);
            checks++;
            if (got_addr[i] !== ea || got_data[i] !== xval(ea)) begin
                $display("FAIL wrap_word%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_data[i], ea, xval(ea));
                failures++;
            end
        end
        checks++;
        if (checksum !== (xval(5'd30) ^ xval(5'd31) ^ xval(5'd0) ^ xval(5'd1))) begin
            $display("FAIL wrap_checksum got=%h exp=00000000", checksum);
            failures++;
        end
        step();
    endtask

    task automatic test_back_to_back_busy_start();
        int done_t;
        init_regs();
        out_ready = 1'b1;
        start_dump(5'd10, 5'd12);
        step();
        start = 1'b1; first_addr = 5'd2; last_addr = 5'd2;
        collect(50, done_t);
        start = 1'b0;
        checks++;
        if (got_addr.size() != 3) begin
            $display("FAIL busy_start_count got=%0d exp=3", got_addr.size());
            failures++;
        end
        for (int i = 0; i < got_addr.size() && i < 3; i++) begin
            logic [4:0] ea;
            ea = 5'd10 + 5'(i);
            checks++;
            if (got_addr[i] !== ea || got_data[i] !== xval(ea)) begin
                $display("FAIL busy_start_word%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_data[i], ea, xval(ea));
                failures++;
            end
        end
        checks++;
        if (checksum !== 32'h1000_000D) begin
            $display("FAIL busy_start_checksum got=%h exp=1000000d", checksum);
            failures++;
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL busy_start_idle busy=%b exp=0", busy);
            failures++;
        end
    endtask

    task automatic test_stall();
        init_regs();
        out_ready = 1'b0;
        start_dump(5'd5, 5'd5);
        step();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 5'd5 || out_data !== xval(5'd5) || done !== 1'b0) begin
                $display("FAIL stall_hold%0d valid=%b addr=%0d data=%h done=%b exp valid=1 addr=5 data=%h done=0",
                         i, out_valid, out_addr, out_data, done, xval(5'd5));
                failures++;
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || checksum !== xval(5'd5)) begin
            $display("FAIL stall_done done=%b valid=%b sum=%h exp done=1 valid=0 sum=%h",
                     done, out_valid, checksum, xval(5'd5));
            failures++;
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || checksum !== xval(5'd5)) begin
            $display("FAIL stall_idle busy=%b done=%b sum=%h exp busy=0 done=0 sum=%h",
                     busy, done, checksum, xval(5'd5));
            failures++;
        end
    endtask

    task automatic test_snapshot();
        int done_t;
        logic [31:0] exp_d [3];
        init_regs();
        exp_d[0] = xval(5'd6);
        exp_d[1] = 32'hDEAD_BEEF;
        exp_d[2] = xval(5'd8);
        out_ready = 1'b1;
        start_dump(5'd6, 5'd8);
        step();
        regs[6] = 32'h0BAD_F00D;
        regs[7] = 32'hDEAD_BEEF;
        collect(50, done_t);
        checks++;
        if (got_addr.size() != 3) begin
            $display("FAIL snap_count got=%0d exp=3", got_addr.size());
            failures++;
        end
        for (int i = 0; i < got_addr.size() && i < 3; i++) begin
            logic [4:0] ea;
            ea = 5'd6 + 5'(i);
            checks++;
            if (got_addr[i] !== ea || got_data[i] !== exp_d[i]) begin
                $display("FAIL snap_word%0d got=%0d/%h exp=%0d/%h", i, got_addr[i], got_data[i], ea, exp_d[i]);
                failures++;
            end
        end
        checks++;
        if (checksum !== 32'hDEAD_BEE1) begin
            $display("FAIL snap_checksum got=%h exp=deadbee1", checksum);
            failures++;
        end
        step();
    endtask

    task automatic test_reset_abort();
        int  done_t;
        bit  found;
        init_regs();
        out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        found = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (out_valid && out_addr == 5'd3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!found) begin
            $display("FAIL abort_reach_word3 got=absent exp=word 3 in HOLD");
            failures++;
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rf_addr !== 5'd0 ||
            out_addr !== 5'd0 || out_data !== 32'd0 || checksum !== 32'd0) begin
            $display("FAIL abort_state busy=%b done=%b valid=%b rf_addr=%0d out_addr=%0d data=%h sum=%h exp all zero",
                     busy, done, out_valid, rf_addr, out_addr, out_data, checksum);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_quiet%0d done=%b busy=%b exp done=0 busy=0", i, done, busy);
                failures++;
            end
        end
        start_dump(5'd20, 5'd21);
        collect(50, done_t);
        checks++;
        if (got_addr.size() != 2 || got_addr[0] !== 5'd20 || got_data[0] !== xval(5'd20) ||
            got_addr[1] !== 5'd21 || got_data[1] !== xval(5'd21)) begin
            $display("FAIL abort_redump count=%0d exp 2 words 20/%h 21/%h", got_addr.size(), xval(5'd20), xval(5'd21));
            failures++;
        end
        checks++;
        if (checksum !== 32'h0000_0001) begin
            $display("FAIL abort_checksum got=%h exp=00000001", checksum);
            failures++;
        end
        step();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b0;
        init_regs();
        test_reset();
        test_full_dump();
        test_wrap();
        test_back_to_back_busy_start();
        test_stall();
        test_snapshot();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
